im_frame_loader: RTL and testbench
==================================

// Module: im_frame_loader
// PURPOSE
//  Upstream feeder for the 3x3 convolution array. Accepts a raster-order pixel
//  stream (one 13-bit pixel per handshake) and assembles it into the flat
//  32x32 frame bus the conv stage consumes.
//  Presents a complete, stable frame with frame_valid and holds it until the
//  consumer acknowledges. Then it reopens for the next frame.
// PARAMETERS
//  PIX_W  13  bits per pixel
//  IMG_W  32  pixels per row
//  IMG_H  32  rows per frame
// PORTS
//  clk          in   1                    system clock, rising edge
//  rst_n        in   1                    asynchronous reset, active-low
//  pix_in       in   PIX_W                pixel data, raster order (row 0 col 0 first)
//  pix_sof      in   1                    marks the first pixel of a frame; qualified by pix_valid
//  pix_valid    in   1                    pixel offered
//  pix_ready    out  1                    loader can accept a pixel
//  frame_out    out  PIX_W*IMG_W*IMG_H    assembled frame; pixel(r,c) at [PIX_W*(IMG_W*r+c) +: PIX_W]
//  frame_valid  out  1                    frame_out is complete and stable
//  frame_ack    in   1                    consumer has taken the frame
//  sof_err      out  1                    one-cycle pulse on a framing error
// BEHAVIOUR
//  Reset (rst_n low, async)
//   - state=LOAD, idx=0, frame_valid=0, sof_err=0, frame_out=0.
//   - pix_ready=1 once rst_n is deasserted.
//   - Reset asserted mid-frame discards the partial frame.
//  States
//   - LOAD: pix_ready=1.
//   - FULL: pix_ready=0, frame_valid=1.
//   - pix_ready and frame_valid are decoded from the state register only; no
//     combinational path from pix_valid or frame_ack.
//  Accept rule
//   - A pixel is accepted when pix_valid && pix_ready.
//   - idx is 0..IMG_W*IMG_H-1, one linear counter; row/col wrap is implicit in
//     the linear index.
//  In LOAD, on an accepted pixel:
//   - pix_sof=1, idx==0: write slot 0, idx<=1.
//   - pix_sof=1, idx!=0 (resync): write slot 0, idx<=1, sof_err pulses next cycle.
//   - pix_sof=0, idx==0 (missing SOF): pixel dropped, idx stays 0, sof_err pulses
//     next cycle.
//   - pix_sof=0, idx!=0: write slot idx, idx<=idx+1.
//  Frame completion
//   - When slot IMG_W*IMG_H-1 is written: state<=FULL, idx<=0.
//   - frame_valid rises the cycle after the last pixel handshake (1-cycle latency).
//  FULL
//   - frame_out holds stable.
//   - pix_valid/pix_sof are ignored; no pixel is lost because pix_ready=0.
//   - frame_ack=1 gives state<=LOAD next cycle: frame_valid=0, pix_ready=1.
//   - frame_ack while in LOAD is ignored.
//  Buffer contents
//   - frame_out is not cleared between frames; slots are overwritten in order
//     during the next load.
//   - The consumer must sample frame_out only while frame_valid=1.
//  Datapath
//   - Pixels are stored unmodified (no sign or width change).
//   - Each write is a PIX_W-bit slot enable decoded from idx.
// TESTING
//  1 Full frame: pixel(r,c)=32r+c, sof on the first pixel, pix_valid held high
//    -> frame_valid=1 exactly 1 cycle after the 1024th handshake;
//    -> slice [13*(32*5+7)+:13]==167 and slice [13*1023+:13]==1023.
//  2 Backpressure: keep pix_valid=1 while FULL
//    -> pix_ready=0 and frame_out unchanged for 20 cycles;
//    -> frame_ack pulse, then next cycle frame_valid=0 and pix_ready=1.
//  3 Resync: sof asserted again at pixel index 500
//    -> sof_err pulses 1 cycle;
//    -> that pixel lands in slot 0 and frame_valid follows 1023 further handshakes.
//  4 Missing SOF: first pixel after reset has sof=0, value 77
//    -> dropped, sof_err pulses, idx stays 0; the following sof pixel lands in slot 0.
//  5 Random pix_valid gaps (~50% duty) with frame 2 = 1023-(32r+c)
//    -> frame contents identical to the gap-free run; no duplicated or lost pixels.
//  6 rst_n low at pixel 600, then release
//    -> frame_valid=0, sof_err=0, frame_out=0; a fresh full frame then loads correctly.

Source files
------------

// File: rtl/im_frame_loader_if.sv
// im_frame_loader_if
//  Bundles the raster pixel stream and the assembled-frame handshake used
//  between the upstream feeder, the frame loader and the conv-stage consumer.
//  Ports/signals:
//   pix_in[PIX_W]           pixel data, raster order
//   pix_sof                 first pixel of a frame (qualified by pix_valid)
//   pix_valid / pix_ready   pixel handshake
//   frame_out[PIX_W*N]      assembled frame, pixel(r,c) at [PIX_W*(IMG_W*r+c) +: PIX_W]
//   frame_valid / frame_ack frame handshake
//   sof_err                 one-cycle framing-error pulse
//  Modports:
//   master  pixel source + frame consumer side
//   slave   the loader
interface im_frame_loader_if #(
  parameter int PIX_W = 13,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
);
  logic [PIX_W-1:0]             pix_in;
  logic                         pix_sof;
  logic                         pix_valid;
  logic                         pix_ready;
  logic [PIX_W*IMG_W*IMG_H-1:0] frame_out;
  logic                         frame_valid;
  logic                         frame_ack;
  logic                         sof_err;

  modport master (
    output pix_in, pix_sof, pix_valid, frame_ack,
    input  pix_ready, frame_out, frame_valid, sof_err
  );

  modport slave (
    input  pix_in, pix_sof, pix_valid, frame_ack,
    output pix_ready, frame_out, frame_valid, sof_err
  );
endinterface

// File: rtl/im_frame_loader.sv
// im_frame_loader
//  Collects a raster-order pixel stream into a flat IMG_W x IMG_H frame
//  register for the 3x3 convolution array. A complete frame is presented
//  with frame_valid and held stable until frame_ack, then loading resumes.
//  Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous reset, active-low
//   bus    im_frame_loader_if.slave (pixel stream in, frame out, sof_err)
//  The module parameters must match those of the connected interface.
module im_frame_loader #(
  parameter int PIX_W = 13,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input logic              clk,
  input logic              rst_n,
  im_frame_loader_if.slave bus
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int IDX_W = $clog2(NPIX);
  localparam int FW    = PIX_W * NPIX;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             sof_err_reg;
  logic [FW-1:0]    frame_reg;

  logic             accept;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [NPIX-1:0]  slot_we;

  // Handshake outputs come straight from the state register so neither
  // pix_valid nor frame_ack has a combinational path to them.
  assign bus.pix_ready   = (state_reg == LOAD);
  assign bus.frame_valid = (state_reg == FULL);
  assign bus.sof_err     = sof_err_reg;
  assign bus.frame_out   = frame_reg;

  assign accept = bus.pix_valid && (state_reg == LOAD);
  // A non-SOF pixel arriving at index 0 has no frame to belong to: drop it.
  assign wr_en  = accept && (bus.pix_sof || (idx_reg != '0));
  // SOF always restarts at slot 0, even mid-frame (resync).
  assign wr_idx = bus.pix_sof ? '0 : idx_reg;

  // One write enable per PIX_W-bit slot.
  generate
    for (genvar gi = 0; gi < NPIX; gi++) begin : g_slot_we
      assign slot_we[gi] = wr_en && (wr_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_reg <= '0;
    end else begin
      for (int i = 0; i < NPIX; i++) begin
        if (slot_we[i]) frame_reg[PIX_W*i +: PIX_W] <= bus.pix_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= LOAD;
      idx_reg     <= '0;
      sof_err_reg <= 1'b0;
    end else begin
      sof_err_reg <= 1'b0;
      case (state_reg)
        LOAD: begin
          if (accept) begin
            if (bus.pix_sof) begin
              sof_err_reg <= (idx_reg != '0);
              idx_reg     <= IDX_W'(1);
            end else if (idx_reg == '0) begin
              sof_err_reg <= 1'b1;
            end else if (idx_reg == LAST_IDX) begin
              state_reg <= FULL;
              idx_reg   <= '0;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        FULL: begin
          if (bus.frame_ack) state_reg <= LOAD;
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_im_frame_loader.sv
// tb_im_frame_loader
//  Randomized stimulus for im_frame_loader with a queue-based reference model
//  and a scoreboard of expected frames consumed by an independent monitor.
module tb_im_frame_loader;

  localparam int PIX_W = 13;
  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int FW    = PIX_W * NPIX;

  logic clk;
  logic rst_n;

  im_frame_loader_if #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

  im_frame_loader #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: pixels of the frame currently being collected,
  // expected frames in delivery order, and framing errors expected so far.
  logic [PIX_W-1:0] pq[$];
  logic [FW-1:0]    exp_q[$];
  int               err_exp    = 0;
  int               err_seen   = 0;
  int               frames_pushed = 0;
  int               frames_done   = 0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Frame rules: SOF starts a new frame (error if one was in progress),
  // a non-SOF pixel with no frame in progress is dropped as an error,
  // and the 1024th collected pixel completes the frame.
  task automatic model_accept(input logic [PIX_W-1:0] v, input logic s,
                              output bit err, output bit done);
    logic [FW-1:0] f;
    err  = 0;
    done = 0;
    if (s) begin
      if (pq.size() != 0) err = 1;
      pq.delete();
      pq.push_back(v);
    end else if (pq.size() == 0) begin
      err = 1;
    end else begin
      pq.push_back(v);
    end
    if (pq.size() == NPIX) begin
      f = '0;
      for (int i = 0; i < NPIX; i++) f[PIX_W*i +: PIX_W] = pq[i];
      exp_q.push_back(f);
      frames_pushed++;
      pq.delete();
      done = 1;
    end
    if (err) err_exp++;
  endtask

  // Offer one pixel, wait for the handshake, then check the per-pixel response.
  task automatic send(input logic [PIX_W-1:0] v, input logic s);
    int budget;
    bit err, done;
    budget = 0;
    bus.pix_in    = v;
    bus.pix_sof   = s;
    bus.pix_valid = 1'b1;
    while (!bus.pix_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.pix_ready) begin
      chk(0, "pix_ready_timeout", 0, 1);
      return;
    end
    @(posedge clk);
    model_accept(v, s, err, done);
    @(negedge clk);
    chk(bus.sof_err == err, "sof_err_pulse", bus.sof_err, err);
    chk(bus.frame_valid == done, "frame_valid_latency", bus.frame_valid, done);
  endtask

  function automatic logic [PIX_W-1:0] pix_val(input int kind, input int i);
    case (kind)
      0:       return PIX_W'(i);
      1:       return PIX_W'(1023 - i);
      default: return PIX_W'($urandom_range(0, (1 << PIX_W) - 1));
    endcase
  endfunction

  task automatic gap(input bit gaps);
    if (gaps && $urandom_range(0, 1) == 1) begin
      bus.pix_valid = 1'b0;
      bus.pix_sof   = $urandom_range(0, 1);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic send_pixels(input int kind, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      send(pix_val(kind, i), i == 0);
      gap(gaps);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    bus.pix_valid = 1'b0;
    while ((frames_done != frames_pushed || bus.frame_valid) && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    chk(frames_done == frames_pushed, "drain_frames", frames_done, frames_pushed);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    #1;
    chk(bus.frame_valid == 1'b0, "rst_frame_valid", bus.frame_valid, 0);
    chk(bus.sof_err == 1'b0, "rst_sof_err", bus.sof_err, 0);
    chk(bus.frame_out == '0, "rst_frame_out_zero", (bus.frame_out == '0), 1);
    pq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(bus.pix_ready == 1'b1, "rst_pix_ready", bus.pix_ready, 1);
  endtask

  // Stimulus
  initial begin
    rst_n         = 1'b0;
    bus.pix_in    = '0;
    bus.pix_sof   = 1'b0;
    bus.pix_valid = 1'b0;
    #1;
    chk(bus.frame_valid == 1'b0, "init_frame_valid", bus.frame_valid, 0);
    chk(bus.sof_err == 1'b0, "init_sof_err", bus.sof_err, 0);
    chk(bus.frame_out == '0, "init_frame_out_zero", (bus.frame_out == '0), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(bus.pix_ready == 1'b1, "init_pix_ready", bus.pix_ready, 1);

    // Missing SOF on the first pixel, then a gap-free ramp frame.
    send(PIX_W'(77), 1'b0);
    send_pixels(0, NPIX, 0);
    // Inverted ramp with random valid gaps.
    send_pixels(1, NPIX, 1);
    // Resync: SOF reappears at stream index 500.
    send_pixels(2, 500, 0);
    send_pixels(2, NPIX, 0);
    drain();
    // Reset mid-frame at pixel 600, then a fresh frame.
    send_pixels(2, 600, 1);
    do_reset();
    send_pixels(0, NPIX, 1);
    send_pixels(2, NPIX, 1);
    drain();
    repeat (5) @(negedge clk);
    chk(err_seen == err_exp, "sof_err_pulse_count", err_seen, err_exp);
    chk(pq.size() == 0 && exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Monitor / consumer: compares each presented frame against the scoreboard.
  initial begin
    bit            prev_fv;
    bit            ok;
    int            bad;
    logic [FW-1:0] expf;
    logic [FW-1:0] snap;
    prev_fv       = 1'b0;
    bus.frame_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.frame_valid && !prev_fv) begin
        if (exp_q.size() == 0) begin
          chk(0, "frame_unexpected", 1, 0);
        end else begin
          expf = exp_q.pop_front();
          bad  = -1;
          for (int i = 0; i < NPIX; i++) begin
            if (bus.frame_out[PIX_W*i +: PIX_W] !== expf[PIX_W*i +: PIX_W]) begin
              bad = i;
              break;
            end
          end
          chk(bad < 0, $sformatf("frame%0d_data_slot%0d", frames_done, bad),
              (bad < 0) ? 0 : bus.frame_out[PIX_W*bad +: PIX_W],
              (bad < 0) ? 0 : expf[PIX_W*bad +: PIX_W]);
        end
        if (frames_done == 0) begin
          chk(bus.frame_out[PIX_W*(32*5+7) +: PIX_W] == 167, "slice_r5c7",
              bus.frame_out[PIX_W*(32*5+7) +: PIX_W], 167);
          chk(bus.frame_out[PIX_W*1023 +: PIX_W] == 1023, "slice_1023",
              bus.frame_out[PIX_W*1023 +: PIX_W], 1023);
          // Hold the frame for 20 cycles while the source keeps offering.
          snap = bus.frame_out;
          ok   = 1'b1;
          repeat (20) begin
            @(negedge clk);
            if (bus.pix_ready !== 1'b0 || bus.frame_out !== snap || bus.frame_valid !== 1'b1)
              ok = 1'b0;
          end
          chk(ok, "backpressure_hold", ok, 1);
          chk(bus.pix_valid == 1'b1, "source_offering_during_hold", bus.pix_valid, 1);
        end else begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        bus.frame_ack = 1'b1;
        @(negedge clk);
        bus.frame_ack = 1'b0;
        chk(bus.frame_valid == 1'b0 && bus.pix_ready == 1'b1, "ack_release",
            {bus.frame_valid, bus.pix_ready}, 1);
        frames_done++;
      end
      prev_fv = bus.frame_valid;
    end
  end

  // Counts cycles with sof_err high; a stuck or stretched pulse shows up here.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.sof_err) err_seen++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
